pq_cmd_sched: RTL

- Command scheduler in front of the systolic priority-queue cell array.
- Arbitrates push/pop/drop requests from NR requesters using round-robin, and issues exactly one command at a time to the head cell.
- Waits for the head cell's valid strobe, then returns a response (popped id/priority or error) to the originating requester.
- Sequences the array so that no two commands ever overlap in flight.

---
 rtl/pq_cmd_sched.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/pq_cmd_sched.sv
// pq_cmd_sched: round-robin push/pop/drop scheduler feeding the systolic priority-queue head cell.
// Defining PQ_SCHED_STATS_EN adds saturating per-class response counters with a synchronous clear.
module pq_cmd_sched #(
  parameter int NR  = 4,
  parameter int IW  = 4,
  parameter int PW  = 4,
  parameter int TMO = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NR-1:0]          req_valid_i,
  input  logic [2*NR-1:0]        req_op_i,
  input  logic [IW*NR-1:0]       req_id_i,
  input  logic [PW*NR-1:0]       req_prio_i,
  output logic [NR-1:0]          req_ready_o,
  output logic                   rsp_valid_o,
  output logic [$clog2(NR)-1:0]  rsp_dst_o,
  output logic [IW-1:0]          rsp_id_o,
  output logic [PW-1:0]          rsp_prio_o,
  output logic                   rsp_err_o,
  output logic                   pq_push_o,
  output logic                   pq_pop_o,
  output logic                   pq_drop_o,
  output logic [IW-1:0]          pq_id_o,
  output logic [PW-1:0]          pq_prio_o,
  input  logic                   pq_push_vld_i,
  input  logic                   pq_pop_vld_i,
  input  logic                   pq_drop_vld_i,
  input  logic [IW-1:0]          pq_pop_id_i,
  input  logic [PW-1:0]          pq_pop_prio_i,
  input  logic                   pq_full_i,
  input  logic                   pq_peek_vld_i
`ifdef PQ_SCHED_STATS_EN
  ,
  input  logic                   stat_clr_i,
  output logic [15:0]            stat_push_o,
  output logic [15:0]            stat_pop_o,
  output logic [15:0]            stat_drop_o,
  output logic [15:0]            stat_err_o
`endif
);

  // state  | meaning
  // IDLE   | arbitrate, latch and validate the granted request
  // ISSUE  | one-cycle command strobe to the head cell
  // WAIT   | wait for the matching completion strobe or timeout
  // RESP   | one-cycle response to the granted requester
  localparam int DW = $clog2(NR);
  localparam int CW = $clog2(TMO);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_DROP = 2'b10;

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] rr_q, rr_d;
  logic [DW-1:0] dst_q, dst_d;
  logic [1:0]    op_q, op_d;
  logic [IW-1:0] id_q, id_d;
  logic [PW-1:0] prio_q, prio_d;
  logic          err_q, err_d;
  logic [IW-1:0] rid_q, rid_d;
  logic [PW-1:0] rprio_q, rprio_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [1:0]    op_a   [NR];
  logic [IW-1:0] id_a   [NR];
  logic [PW-1:0] prio_a [NR];

  for (genvar i = 0; i < NR; i++) begin : g_unpack
    assign op_a[i]   = req_op_i[2*i +: 2];
    assign id_a[i]   = req_id_i[IW*i +: IW];
    assign prio_a[i] = req_prio_i[PW*i +: PW];
  end

  logic          found;
  logic [DW-1:0] gnt;
  logic [DW:0]   sum;

  // First asserted requester at or after the round-robin pointer, with wrap.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    sum   = '0;
    for (int i = 0; i < NR; i++) begin
      sum = {1'b0, rr_q} + (DW+1)'(i);
      if (sum >= (DW+1)'(NR)) sum = sum - (DW+1)'(NR);
      if (!found && req_valid_i[sum[DW-1:0]]) begin
        found = 1'b1;
        gnt   = sum[DW-1:0];
      end
    end
  end

  logic       bad;
  logic       match;
  logic [NR-1:0] ready_c;

  always_comb begin
    case (op_a[gnt])
      OP_PUSH: bad = pq_full_i || (id_a[gnt] == '0);
      OP_POP:  bad = !pq_peek_vld_i;
      OP_DROP: bad = (id_a[gnt] == '0);
      default: bad = 1'b1;
    endcase
  end

  assign match = ((op_q == OP_PUSH) && pq_push_vld_i) ||
                 ((op_q == OP_POP)  && pq_pop_vld_i)  ||
                 ((op_q == OP_DROP) && pq_drop_vld_i);

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    dst_d   = dst_q;
    op_d    = op_q;
    id_d    = id_q;
    prio_d  = prio_q;
    err_d   = err_q;
    rid_d   = rid_q;
    rprio_d = rprio_q;
    cnt_d   = cnt_q;
    ready_c = '0;
    case (state_q)
      S_IDLE: begin
        if (found && !rst_i) begin
          ready_c[gnt] = 1'b1;
          dst_d   = gnt;
          op_d    = op_a[gnt];
          id_d    = id_a[gnt];
          prio_d  = prio_a[gnt];
          err_d   = bad;
          rid_d   = '0;
          rprio_d = '0;
          rr_d    = (gnt == DW'(NR-1)) ? '0 : gnt + DW'(1);
          state_d = bad ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A strobe seen on the last counted cycle still beats the timeout.
        if (match) begin
          if (op_q == OP_POP) begin
            rid_d   = pq_pop_id_i;
            rprio_d = pq_pop_prio_i;
          end
          state_d = S_RESP;
        end else if (cnt_q == CW'(TMO-1)) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      dst_q   <= '0;
      op_q    <= '0;
      id_q    <= '0;
      prio_q  <= '0;
      err_q   <= 1'b0;
      rid_q   <= '0;
      rprio_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      dst_q   <= dst_d;
      op_q    <= op_d;
      id_q    <= id_d;
      prio_q  <= prio_d;
      err_q   <= err_d;
      rid_q   <= rid_d;
      rprio_q <= rprio_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready_o = ready_c;
  assign pq_push_o   = (state_q == S_ISSUE) && (op_q == OP_PUSH);
  assign pq_pop_o    = (state_q == S_ISSUE) && (op_q == OP_POP);
  assign pq_drop_o   = (state_q == S_ISSUE) && (op_q == OP_DROP);
  assign pq_id_o     = id_q;
  assign pq_prio_o   = prio_q;
  assign rsp_valid_o = (state_q == S_RESP);
  assign rsp_dst_o   = rsp_valid_o ? dst_q : '0;
  assign rsp_err_o   = rsp_valid_o && err_q;
  assign rsp_id_o    = rsp_valid_o ? rid_q : '0;
  assign rsp_prio_o  = rsp_valid_o ? rprio_q : '0;

`ifdef PQ_SCHED_STATS_EN
  logic [15:0] st_push_q, st_pop_q, st_drop_q, st_err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || stat_clr_i) begin
      st_push_q <= '0;
      st_pop_q  <= '0;
      st_drop_q <= '0;
      st_err_q  <= '0;
    end else if (state_q == S_RESP) begin
      if (err_q) begin
        if (st_err_q != 16'hFFFF) st_err_q <= st_err_q + 16'd1;
      end else begin
        case (op_q)
          OP_PUSH: if (st_push_q != 16'hFFFF) st_push_q <= st_push_q + 16'd1;
          OP_POP:  if (st_pop_q  != 16'hFFFF) st_pop_q  <= st_pop_q  + 16'd1;
          OP_DROP: if (st_drop_q != 16'hFFFF) st_drop_q <= st_drop_q + 16'd1;
          default: ;
        endcase
      end
    end
  end

  assign stat_push_o = st_push_q;
  assign stat_pop_o  = st_pop_q;
  assign stat_drop_o = st_drop_q;
  assign stat_err_o  = st_err_q;
`endif

endmodule
